// File: rtl/aec_calc_if.sv
// aec_calc_if: character stream in, busy/valid/error/result out for the expression calculator
interface aec_calc_if #(parameter int DATA_W = 7);
  logic ready;
  logic [7:0] ascii_in;
  logic busy;
  logic valid;
  logic error;
  logic [DATA_W-1:0] result;
  modport master(output ready, ascii_in, input busy, valid, error, result);
  modport slave(input ready, ascii_in, output busy, valid, error, result);
endinterface

// File: rtl/aec_calc.sv
// aec_calc: infix ASCII expression calculator (shunting-yard to postfix, then stack evaluation)
module aec_calc #(
  parameter int DATA_W = 7,
  parameter int MAX_LEN = 16,
  parameter int STK_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  aec_calc_if.slave bus
);
  localparam int TW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(STK_DEPTH + 1);
  localparam logic [4:0] T_LP = 5'h10, T_RP = 5'h11, T_MUL = 5'h12, T_ADD = 5'h13;
  localparam logic [4:0] T_SUB = 5'h14, T_EQ = 5'h15, T_BAD = 5'h1f;
  typedef enum logic [2:0] {IDLE, LOAD, CONV, EVAL, DONE} state_t;
  state_t state;
  // Tokens: bit 4 clear = operand value in [3:0], set = operator/punctuation code.
  // Arrays carry one spare entry so every pointer width matches its index width.
  logic [4:0] tok [MAX_LEN+1];
  logic [4:0] pf [MAX_LEN+1];
  logic [4:0] ostk [STK_DEPTH+1];
  logic [DATA_W-1:0] vstk [STK_DEPTH+1];
  logic [TW-1:0] tcnt, tp, pcnt, ep;
  logic [SW-1:0] osp, vsp;
  logic err, busy, valid, error;
  logic [DATA_W-1:0] result;
  logic [7:0] c;
  logic [4:0] ctok, t, e, top;
  logic [DATA_W-1:0] a, b, alu;
  logic pop, fin_err;
  assign c = bus.ascii_in;
  assign ctok = (c >= "0" && c <= "9") ? {1'b0, c[3:0]} :
                (c >= "a" && c <= "f") ? {1'b0, c[3:0] + 4'd9} :
                c == "(" ? T_LP : c == ")" ? T_RP : c == "*" ? T_MUL :
                c == "+" ? T_ADD : c == "-" ? T_SUB : c == "=" ? T_EQ : T_BAD;
  assign t = tok[tp];
  assign e = pf[ep];
  assign top = ostk[osp - SW'(1)];
  // ')' '+' '-' '=' unwind to the nearest '('; '*' only pops an equal-precedence '*'
  assign pop = osp != '0 && (t == T_MUL ? top == T_MUL : t != T_LP && top != T_LP);
  assign a = vstk[vsp - SW'(2)];
  assign b = vstk[vsp - SW'(1)];
  assign alu = e == T_MUL ? a * b : e == T_ADD ? a + b : a - b;
  assign fin_err = err | (vsp != SW'(1));
  assign bus.busy = busy;
  assign bus.valid = valid;
  assign bus.error = error;
  assign bus.result = result;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      valid <= 1'b0;
      error <= 1'b0;
      result <= '0;
      err <= 1'b0;
      tcnt <= '0;
      tp <= '0;
      pcnt <= '0;
      ep <= '0;
      osp <= '0;
      vsp <= '0;
    end else begin
      case (state)
        IDLE, LOAD: if (bus.ready) begin
          if (ctok == T_EQ) begin
            tok[tcnt] <= T_EQ;
            state <= CONV;
            busy <= 1'b1;
            if (tcnt == '0) err <= 1'b1;
          end else begin
            state <= LOAD;
            if (ctok == T_BAD || tcnt == TW'(MAX_LEN)) err <= 1'b1;
            else begin
              tok[tcnt] <= ctok;
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        CONV: if (err) begin
          state <= DONE;
          valid <= 1'b1;
          error <= 1'b1;
          result <= '0;
        end else if (!t[4]) begin
          pf[pcnt] <= t;
          pcnt <= pcnt + TW'(1);
          tp <= tp + TW'(1);
        end else if (pop) begin
          pf[pcnt] <= top;
          pcnt <= pcnt + TW'(1);
          osp <= osp - SW'(1);
        end else if (t == T_RP) begin
          if (osp == '0) err <= 1'b1;
          else begin
            osp <= osp - SW'(1);
            tp <= tp + TW'(1);
          end
        end else if (t == T_EQ) begin
          if (osp != '0) err <= 1'b1;
          else state <= EVAL;
        end else if (osp == SW'(STK_DEPTH)) err <= 1'b1;
        else begin
          ostk[osp] <= t;
          osp <= osp + SW'(1);
          tp <= tp + TW'(1);
        end
        EVAL: if (err || ep == pcnt) begin
          state <= DONE;
          valid <= 1'b1;
          error <= fin_err;
          result <= fin_err ? '0 : vstk[0];
        end else begin
          ep <= ep + TW'(1);
          if (!e[4]) begin
            if (vsp == SW'(STK_DEPTH)) err <= 1'b1;
            else begin
              vstk[vsp] <= DATA_W'(e[3:0]);
              vsp <= vsp + SW'(1);
            end
          end else if (vsp < SW'(2)) err <= 1'b1;
          else begin
            vstk[vsp - SW'(2)] <= alu;
            vsp <= vsp - SW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          valid <= 1'b0;
          err <= 1'b0;
          tcnt <= '0;
          tp <= '0;
          pcnt <= '0;
          ep <= '0;
          osp <= '0;
          vsp <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
